// File: rtl/data_path.sv
// data_path: 16-bit processor datapath.
//   - 16 x 16 register file: two combinational read ports (A, B), one
//     synchronous write port fed by the write-back mux.
//   - 256 x 16 data memory: combinational read, synchronous write of A.
//   - 3-bit-select ALU with results taken modulo 2^16, and no flags.
//   - Write-back mux: ALU result or memory read data.
// The controller supplies every control and address input.
// Reset is asynchronous and active-high. It clears only the register file.
// Optional build macro DMEM_PRELOAD_EN: when it is defined, data memory
// powers up with M[0] = 123 and all other words 0. When it is undefined,
// all memory words power up as 0.
module data_path (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        D_wr,
    input  logic        RF_W_en,
    input  logic        RF_s,
    input  logic [7:0]  D_Addr,
    input  logic [3:0]  RF_W_addr,
    input  logic [3:0]  RF_Ra_addr,
    input  logic [3:0]  RF_Rb_addr,
    input  logic [2:0]  Alu_s0,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic [15:0] ALU_Out
);

    localparam int NUM_REGS  = 16;
    localparam int MEM_WORDS = 256;

    // Register file storage.
    logic [15:0] r_rf [NUM_REGS];

    // Data memory storage. The memory has no reset, so its contents come
    // only from the power-up value.
`ifdef DMEM_PRELOAD_EN
    logic [15:0] r_mem [MEM_WORDS] = '{0: 16'd123, default: 16'd0};
`else
    logic [15:0] r_mem [MEM_WORDS] = '{default: 16'd0};
`endif

    logic [NUM_REGS-1:0] w_we;
    logic [15:0]         w_mem_rdata;
    logic [15:0]         w_wdata;
    logic [15:0]         w_alu;

    // Decode one write strobe for each register from the write address.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_we_dec
            assign w_we[gi] = RF_W_en && (RF_W_addr == 4'(gi));
        end
    endgenerate

    // Read ports and memory read are combinational. A also drives the
    // memory write data.
    assign A           = r_rf[RF_Ra_addr];
    assign B           = r_rf[RF_Rb_addr];
    assign w_mem_rdata = r_mem[D_Addr];

    // Write-back mux. mem_rdata is the value from before the edge, so a
    // store and a load to one address in the same cycle loads the old word.
    assign w_wdata = RF_s ? w_mem_rdata : w_alu;

    // ALU: every result wraps to 16 bits.
    always_comb begin
        w_alu = '0;
        case (Alu_s0)
            3'd0:    w_alu = '0;
            3'd1:    w_alu = A + B;
            3'd2:    w_alu = A - B;
            3'd3:    w_alu = A;
            3'd4:    w_alu = A ^ B;
            3'd5:    w_alu = A | B;
            3'd6:    w_alu = A & B;
            3'd7:    w_alu = A + 16'd1;
            default: w_alu = '0;
        endcase
    end

    assign ALU_Out = w_alu;

    // Register file write. Reset clears every register at once and blocks
    // writes while it is held.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_we[i]) begin
                    r_rf[i] <= w_wdata;
                end
            end
        end
    end

    // Data memory write. Reset has no effect here, so stores still happen
    // while Reset is asserted.
    always_ff @(posedge Clk) begin
        if (D_wr) begin
            r_mem[D_Addr] <= A;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: a scoreboard bench for data_path.
// The stimulus process drives the inputs on each falling edge. It computes
// the expected A/B/ALU_Out from a reference model of the architectural
// state and pushes that expectation into a queue. It then applies the
// effect of the next rising edge to the model. A separate monitor samples
// the DUT 2 ns after each falling edge and compares it against the oldest
// queued expectation.
module tb_data_path;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        D_wr;
    logic        RF_W_en;
    logic        RF_s;
    logic [7:0]  D_Addr;
    logic [3:0]  RF_W_addr;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  Alu_s0;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] ALU_Out;

    data_path dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .D_wr       (D_wr),
        .RF_W_en    (RF_W_en),
        .RF_s       (RF_s),
        .D_Addr     (D_Addr),
        .RF_W_addr  (RF_W_addr),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .Alu_s0     (Alu_s0),
        .A          (A),
        .B          (B),
        .ALU_Out    (ALU_Out)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] alu;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model of the architectural state.
    logic [15:0] m_rf  [16];
    logic [15:0] m_mem [256];

    // Reference ALU, written straight from the function table.
    function automatic logic [15:0] ref_alu(input logic [2:0] sel,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
        int unsigned r;
        case (sel)
            3'd1:    r = (int'(a) + int'(b)) % 65536;
            3'd2:    r = (65536 + int'(a) - int'(b)) % 65536;
            3'd3:    r = a;
            3'd4:    r = a ^ b;
            3'd5:    r = a | b;
            3'd6:    r = a & b;
            3'd7:    r = (int'(a) + 1) % 65536;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // One transaction: drive the inputs, record the expectation, and then
    // advance the model across the next rising edge.
    task automatic step(input string tag, input logic rst, input logic dwr,
                        input logic wen, input logic rfs,
                        input logic [7:0] addr, input logic [3:0] wa,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [2:0] sel);
        exp_t        e;
        logic [15:0] wb;
        @(negedge Clk);
        Reset      = rst;
        D_wr       = dwr;
        RF_W_en    = wen;
        RF_s       = rfs;
        D_Addr     = addr;
        RF_W_addr  = wa;
        RF_Ra_addr = ra;
        RF_Rb_addr = rb;
        Alu_s0     = sel;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_rf[i] = 16'd0;
        end
        e.a   = m_rf[ra];
        e.b   = m_rf[rb];
        e.alu = ref_alu(sel, e.a, e.b);
        e.tag = tag;
        sb_q.push_back(e);
        wb = rfs ? m_mem[addr] : e.alu;
        if (!rst && wen) m_rf[wa] = wb;
        if (dwr) m_mem[addr] = e.a;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({e.tag, ".A"}, A, e.a);
                chk({e.tag, ".B"}, B, e.b);
                chk({e.tag, ".ALU"}, ALU_Out, e.alu);
                $display("txn %-10s A=%h B=%h ALU=%h (exp %h %h %h)",
                         e.tag, A, B, ALU_Out, e.a, e.b, e.alu);
            end
        end
    end

    // Stimulus.
    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 16'd0;
`ifdef DMEM_PRELOAD_EN
        m_mem[0] = 16'd123;
`endif
        for (int i = 0; i < 16; i++) m_rf[i] = 16'd0;
        Reset = 1'b1; D_wr = 1'b0; RF_W_en = 1'b0; RF_s = 1'b0;
        D_Addr = 8'd0; RF_W_addr = 4'd0; RF_Ra_addr = 4'd0;
        RF_Rb_addr = 4'd0; Alu_s0 = 3'd0;

        //        tag          rst dwr wen rfs addr wa ra rb sel
        step("por",        1, 0, 0, 0, 8'd0, 0, 0, 0, 3'd0);
        step("r5_inc",     0, 0, 1, 0, 8'd0, 5, 0, 0, 3'd7);
        step("r5_inc2",    0, 0, 1, 0, 8'd0, 5, 5, 5, 3'd7);
        // Reset asserted mid-cycle: zeros must show before any edge. The
        // write that is attempted under reset is blocked, but the store
        // still goes through.
        step("rst_pulse",  1, 1, 1, 0, 8'd40, 5, 5, 5, 3'd7);
        step("rst_rel",    0, 0, 0, 1, 8'd40, 6, 5, 5, 3'd7);
        step("ld40",       0, 0, 1, 1, 8'd40, 6, 6, 5, 3'd0);
        step("chk40",      0, 0, 0, 0, 8'd0, 0, 6, 5, 3'd1);
        // Load M[0] into R0.
        step("load0",      0, 0, 1, 1, 8'd0, 0, 0, 0, 3'd0);
        step("load0_chk",  0, 0, 0, 0, 8'd0, 0, 0, 0, 3'd3);
        // ALU write-back and the individual ALU functions.
        step("alu_wb",     0, 0, 1, 0, 8'd0, 2, 0, 0, 3'd1);
        step("add",        0, 0, 0, 0, 8'd0, 0, 2, 0, 3'd1);
        step("sub",        0, 0, 0, 0, 8'd0, 0, 2, 0, 3'd2);
        step("xor",        0, 0, 0, 0, 8'd0, 0, 2, 0, 3'd4);
        step("wrap",       0, 0, 0, 0, 8'd0, 0, 0, 2, 3'd2);
        step("or",         0, 0, 0, 0, 8'd0, 0, 2, 0, 3'd5);
        step("and",        0, 0, 0, 0, 8'd0, 0, 2, 0, 3'd6);
        // Store, then load the stored word back.
        step("store9",     0, 1, 0, 0, 8'd9, 0, 2, 0, 3'd0);
        step("ld9",        0, 0, 1, 1, 8'd9, 3, 2, 0, 3'd0);
        step("chk_r3",     0, 0, 0, 0, 8'd9, 0, 3, 2, 3'd2);
        // Store and load the same address in one cycle (read-before-write).
        step("rbw",        0, 1, 1, 1, 8'd9, 4, 0, 0, 3'd0);
        step("chk_r4",     0, 0, 0, 0, 8'd9, 0, 4, 0, 3'd3);
        step("ld9b",       0, 0, 1, 1, 8'd9, 5, 4, 0, 3'd0);
        step("chk_r5",     0, 0, 0, 0, 8'd9, 0, 5, 4, 3'd1);
        // Read and write one register in the same cycle.
        step("same_rw",    0, 0, 1, 0, 8'd0, 4, 4, 4, 3'd7);
        step("same_rw2",   0, 0, 0, 0, 8'd0, 0, 4, 4, 3'd3);

        // Randomized traffic over a narrow address range, to force
        // collisions between loads and stores.
        for (int n = 0; n < 300; n++) begin
            step("rand",
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 2) == 0),
                 8'($urandom_range(0, 15)),
                 4'($urandom),
                 4'($urandom),
                 4'($urandom),
                 3'($urandom));
        end

        @(negedge Clk);
        @(negedge Clk);
        #4;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_path.md
# data_path

16-bit processor datapath: a 16×16 register file, a 256×16 data memory, a 3-bit-select ALU and a 2:1 write-back mux, connected in a single clock domain. The controller drives every control and address input. The block exposes both register read ports and the ALU result. Supported operations are register-to-register ALU ops, loads (memory to register) and stores (register A to memory).

## Interface
- No parameters. Widths are fixed: data 16 bits, memory address 8 bits, register address 4 bits, ALU select 3 bits.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears the register file.
- D_wr  in  1  data-memory write enable.
- RF_W_en  in  1  register-file write enable.
- RF_s  in  1  write-back select: 0 = ALU result, 1 = memory read data.
- D_Addr  in  8  data-memory address, used for both read and write.
- RF_W_addr  in  4  register write address.
- RF_Ra_addr  in  4  register read address, port A.
- RF_Rb_addr  in  4  register read address, port B.
- Alu_s0  in  3  ALU function select.
- A  out  16  register port A read data; also the memory write data.
- B  out  16  register port B read data.
- ALU_Out  out  16  ALU result.

## Operation
- Register file: 16 × 16-bit registers.
  - Two combinational read ports: A = R[RF_Ra_addr], B = R[RF_Rb_addr].
  - One synchronous write port: R[RF_W_addr] <= W_data on a rising edge while RF_W_en=1.
- Write-back mux: W_data = RF_s ? mem_rdata : ALU_Out.
- Data memory: 256 × 16-bit.
  - Read is combinational: mem_rdata = M[D_Addr].
  - Write is synchronous: M[D_Addr] <= A on a rising edge while D_wr=1.
- ALU: combinational. All results are taken modulo 2^16; there are no flags and no carry out.
  - 0: 0
  - 1: A + B
  - 2: A − B
  - 3: A
  - 4: A ^ B
  - 5: A | B
  - 6: A & B
  - 7: A + 1
- Store-and-load from the same address in one cycle (D_wr=1, RF_W_en=1, RF_s=1): the register receives the memory contents from before the edge (read-before-write). The memory takes A.
- Same register read and written in one cycle: the read ports show the old value until the edge, then the new value.
- Register 0 is an ordinary writable register.

## Timing
- A, B, ALU_Out and W_data are purely combinational from the addresses, Alu_s0, RF_s and the stored state.
- Load latency: 1 edge. After the rising edge with RF_W_en=1, R[RF_W_addr] holds the written value and is visible on A/B in the same cycle.
- Store latency: 1 edge. M[D_Addr] is updated at the edge and readable via mem_rdata immediately after.
- Reset:
  - Asserting Reset immediately clears all 16 registers to 0, with no clock required. Register writes are blocked while Reset=1.
  - Reset outputs are A=0 and B=0. ALU_Out = 0 for Alu_s0 = 0–6 and 1 for Alu_s0 = 7.
  - Data memory is not affected by Reset; memory writes still occur while Reset=1.
  - Reset deasserted mid-cycle: the next rising edge operates normally.

## Configuration
- DMEM_PRELOAD_EN:
  - Defined: data memory powers up with M[0] = 16'd123 (0x007B) and all other words 0.
  - Undefined: every memory word powers up as 0.
- The test plan requires the macro defined.

## Test plan
- Reset pulse while R5 is nonzero, with Ra=5, Rb=5, Alu_s0=7 -> A=0, B=0 and ALU_Out=1 immediately, before any clock edge.
- Load: RF_s=1, D_Addr=0, RF_W_addr=0, RF_W_en=1 for one edge; then Rb=0 -> B=123.
- ALU write-back: R0=123, Ra=0, Rb=0, Alu_s0=1, RF_s=0, RF_W_addr=2, one edge -> R2=246. Then Ra=2, Rb=0:
  - Alu_s0=1 -> ALU_Out=369.
  - Alu_s0=2 -> ALU_Out=123.
  - Alu_s0=4 -> ALU_Out=0x008D.
- Wraparound: Ra=0 (123), Rb=2 (246), Alu_s0=2 -> ALU_Out=0xFF85.
- Store then load: Ra=2 (246), D_Addr=9, D_wr=1, one edge -> M[9]=246. Then RF_s=1, RF_W_addr=3, RF_W_en=1, one edge -> R3=246.
- Read-before-write: Ra=0 (123), D_Addr=9, D_wr=1, RF_W_en=1, RF_s=1, RF_W_addr=4, one edge -> R4=246 and M[9]=123.
